scan_chain_ctrl: RTL

Sequencer for one scan chain of CHAIN_LEN mcu9t5v0 scan flip-flops sharing the controller clock. It drives the chain's shared SE and the head flop's SI, and samples the tail flop's Q (SO).
- On START it shifts a parallel pattern into the chain, runs CAP_CYCLES functional capture cycles, then shifts the captured state out into a parallel RESULT register.
- It sits between the on-chip test/BIST logic and the scan chain.

---
 rtl/scan_ctrl_pkg.sv | 15 +
 rtl/scan_shift_reg.sv | 63 ++++++
 rtl/scan_chain_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/scan_ctrl_pkg.sv
// Shared definitions for the scan chain controller.
//   state_e : sequencer states (IDLE / SHIFT / CAPTURE / UNLOAD)
//   STATE_W : width of the state encoding
package scan_ctrl_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_UNLOAD  = 2'd3
  } state_e;

endpackage

// File: rtl/scan_shift_reg.sv
// Pattern shadow register and result assembly for the scan controller.
//   clk_i, rn_i  : clock, synchronous active-low reset
//   load_i       : capture pat_i into the shadow register
//   shift_i      : advance the shadow register one bit toward the MSB
//   pat_i        : parallel pattern
//   next_bit_o   : the bit that becomes the MSB after the next shift
//   unload_i     : write so_i into result bit idx_i
//   idx_i        : result bit index
//   so_i         : serial data from the chain tail
//   result_o     : assembled parallel result
module scan_shift_reg #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rn_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [N-1:0]     pat_i,
  output logic             next_bit_o,
  input  logic             unload_i,
  input  logic [CNT_W-1:0] idx_i,
  input  logic             so_i,
  output logic [N-1:0]     result_o
);

  logic [N-1:0] shadow_q, shadow_d;
  logic [N-1:0] result_q, result_d;

  // The MSB itself is driven straight from pat_i on the load edge, so the
  // serial stream continues from bit N-2 of the shadow copy.
  assign next_bit_o = shadow_q[N-2];
  assign result_o   = result_q;

  always_comb begin
    shadow_d = shadow_q;
    if (load_i) begin
      shadow_d = pat_i;
    end else if (shift_i) begin
      shadow_d = {shadow_q[N-2:0], 1'b0};
    end
  end

  always_comb begin
    result_d = result_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (unload_i && (idx_i == CNT_W'(k))) begin
        result_d[k] = so_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rn_i) begin
      shadow_q <= '0;
      result_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      result_q <= result_d;
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Load / capture / unload sequencer for a single scan chain.
//   CLK    : rising-edge clock shared with the chain
//   RN     : synchronous active-low reset
//   START  : begin a sequence (sampled in IDLE only)
//   PAT    : pattern to load; PAT[k] ends up in chain flop k
//   SO     : Q of the last chain flop
//   SE     : scan enable to every chain flop
//   SI     : scan input to chain flop 0
//   RESULT : unloaded chain state; RESULT[k] = flop k after capture
//   BUSY   : sequence in progress
//   DONE   : one-cycle pulse, RESULT valid from this cycle
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned CHAIN_LEN  = 8,
  parameter int unsigned CAP_CYCLES = 1,
  parameter int unsigned CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic [CHAIN_LEN-1:0] RESULT,
  output logic                 BUSY,
  output logic                 DONE
);

  // The one counter also times CAPTURE, so widen it if CAP_CYCLES needs more
  // bits than the chain length does.
  localparam int unsigned CAP_W = $clog2(CAP_CYCLES + 1);
  localparam int unsigned CW    = (CNT_W > CAP_W) ? CNT_W : CAP_W;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          se_q, se_d;
  logic          si_q, si_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          load;
  logic          shift;
  logic          unload;
  logic          next_bit;
  logic [CNT_W-1:0] idx;

  // Unload fills RESULT from the top bit down: the j-th unload edge (cnt=j-1)
  // writes bit N-j.
  assign idx = CNT_W'(CW'(CHAIN_LEN - 1) - cnt_q);

  scan_shift_reg #(
    .N     (CHAIN_LEN),
    .CNT_W (CNT_W)
  ) u_sreg (
    .clk_i      (CLK),
    .rn_i       (RN),
    .load_i     (load),
    .shift_i    (shift),
    .pat_i      (PAT),
    .next_bit_o (next_bit),
    .unload_i   (unload),
    .idx_i      (idx),
    .so_i       (SO),
    .result_o   (RESULT)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    se_d    = 1'b0;
    si_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    unload  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (START) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          se_d    = 1'b1;
          si_d    = PAT[CHAIN_LEN-1];
          busy_d  = 1'b1;
          load    = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CW'(CHAIN_LEN - 1)) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          se_d  = 1'b1;
          si_d  = next_bit;
          shift = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (cnt_q == CW'(CAP_CYCLES - 1)) begin
          state_d = ST_UNLOAD;
          cnt_d   = '0;
          se_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_UNLOAD: begin
        unload = 1'b1;
        if (cnt_q == CW'(CHAIN_LEN - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          se_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      se_q    <= se_d;
      si_q    <= si_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign SE   = se_q;
  assign SI   = si_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
